// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared, purely combinational 16-bit ALU.
// Requesters are arbitrated round-robin. Each accepted operation moves
// through a three-state sequence: IDLE (grant/accept), EXEC (the ALU sees
// the latched operands and its result is captured) and RESP (the result is
// held for the granted requester until it is consumed).
// Operands reach the ALU only from the latched registers, so the ALU input
// never follows the request ports combinationally.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  // Request side
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [1:0]  req0_op,
  input  logic [1:0]  req1_op,
  // Shared ALU
  output logic [15:0] alu_ain,
  output logic [15:0] alu_bin,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic        alu_n,
  input  logic        alu_v,
  input  logic        alu_z,
  // Response side
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [15:0] rsp_data,
  output logic [2:0]  rsp_flags,
  output logic [2:0]  status_nvz,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  state_e      state_q;
  logic        armed_q;      // low until the first clock edge after reset release
  logic        last_gnt_q;   // most recently served requester
  logic        gnt_q;        // requester owning the operation in flight
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [1:0]  op_q;
  logic [15:0] rsp_data_q;
  logic [2:0]  rsp_flags_q;
  logic [2:0]  status_q;
  logic        rsp0_valid_q;
  logic        rsp1_valid_q;
  logic        busy_q;

  // Arbitration result for the current IDLE cycle
  logic        gnt_d;
  logic        any_valid;
  logic        accept;
  logic        rsp_fire;
  logic [15:0] sel_a;
  logic [15:0] sel_b;
  logic [1:0]  sel_op;

  // Round-robin grant and same-cycle ready generation.
  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_d      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    any_valid  = req0_valid || req1_valid;
    if (state_q == IDLE && armed_q && any_valid) begin
      if (req0_valid && req1_valid) begin
        gnt_d = ~last_gnt_q;
      end else begin
        gnt_d = req1_valid;
      end
      req0_ready = ~gnt_d;
      req1_ready = gnt_d;
    end
  end

  // Accept requires valid, so a requester that drops valid is never served;
  // only the granted response port can complete the response.
  assign accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign rsp_fire = (state_q == RESP) && (gnt_q ? rsp1_ready : rsp0_ready);

  assign sel_a  = gnt_d ? req1_a  : req0_a;
  assign sel_b  = gnt_d ? req1_b  : req0_b;
  assign sel_op = gnt_d ? req1_op : req0_op;

  // Operation sequencer: latches the granted operation, captures the ALU
  // result, and holds the response until the owning requester consumes it.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      last_gnt_q   <= 1'b1;   // requester 0 wins the first tie
      gnt_q        <= 1'b0;
      a_q          <= 16'h0000;
      b_q          <= 16'h0000;
      op_q         <= 2'b00;
      rsp_data_q   <= 16'h0000;
      rsp_flags_q  <= 3'b000;
      status_q     <= 3'b000;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            op_q    <= sel_op;
            gnt_q   <= gnt_d;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // Result and flags are stored bit-for-bit as the ALU drives them.
          rsp_data_q   <= alu_out;
          rsp_flags_q  <= {alu_n, alu_v, alu_z};
          status_q     <= {alu_n, alu_v, alu_z};
          rsp0_valid_q <= ~gnt_q;
          rsp1_valid_q <= gnt_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_fire) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            last_gnt_q   <= gnt_q;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign alu_ain    = a_q;
  assign alu_bin    = b_q;
  assign alu_op     = op_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
  assign status_nvz = status_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. The bench supplies the shared ALU as a
// small behavioural model; every expected value is a hand-computed constant.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] alu_ain, alu_bin;
  logic [1:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_n, alu_v, alu_z;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_flags;
  logic [2:0]  status_nvz;
  logic        busy;

  int n_vec;
  int n_err;

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .alu_ain    (alu_ain),
    .alu_bin    (alu_bin),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .alu_n      (alu_n),
    .alu_v      (alu_v),
    .alu_z      (alu_z),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .rsp_flags  (rsp_flags),
    .status_nvz (status_nvz),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared ALU: add, sub, and, not-B with N/V/Z flags
  always_comb begin
    alu_out = 16'h0000;
    alu_v   = 1'b0;
    case (alu_op)
      2'b00: begin
        alu_out = alu_ain + alu_bin;
        alu_v   = (alu_ain[15] == alu_bin[15]) && (alu_out[15] != alu_ain[15]);
      end
      2'b01: begin
        alu_out = alu_ain - alu_bin;
        alu_v   = (alu_ain[15] != alu_bin[15]) && (alu_out[15] != alu_ain[15]);
      end
      2'b10: alu_out = alu_ain & alu_bin;
      default: alu_out = ~alu_bin;
    endcase
    alu_n = alu_out[15];
    alu_z = (alu_out == 16'h0000);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hard stop in case the sequence below ever stalls
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 16'h0000; req0_b = 16'h0000; req0_op = 2'b00;
    req1_a = 16'h0000; req1_b = 16'h0000; req1_op = 2'b00;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // ---- Reset state, with a request already pending ----
    req0_valid = 1'b1; req0_a = 16'h7FFF; req0_b = 16'h0001; req0_op = 2'b00;
    #2;
    check("rst_req0_ready", 16'(req0_ready), 16'h0);
    check("rst_req1_ready", 16'(req1_ready), 16'h0);
    check("rst_rsp0_valid", 16'(rsp0_valid), 16'h0);
    check("rst_rsp1_valid", 16'(rsp1_valid), 16'h0);
    check("rst_rsp_data",   rsp_data,        16'h0000);
    check("rst_rsp_flags",  16'(rsp_flags),  16'h0);
    check("rst_status",     16'(status_nvz), 16'h0);
    check("rst_alu_ain",    alu_ain,         16'h0000);
    check("rst_alu_bin",    alu_bin,         16'h0000);
    check("rst_alu_op",     16'(alu_op),     16'h0);
    check("rst_busy",       16'(busy),       16'h0);
    tick();
    tick();
    // Release mid-cycle: no accept may happen before the first edge with rst_n high
    rst_n = 1'b1;
    #1;
    check("rel_req0_ready", 16'(req0_ready), 16'h0);

    // ---- Single op: 0x7FFF + 0x0001 ----
    tick();  // first edge with rst_n high, no accept here
    check("op1_busy_idle",  16'(busy),       16'h0);
    check("op1_req0_ready", 16'(req0_ready), 16'h1);
    check("op1_req1_ready", 16'(req1_ready), 16'h0);
    tick();  // accept
    req0_valid = 1'b0;
    req0_a     = 16'h0000;  // latched operands must not follow the port
    #1;
    check("op1_exec_busy",  16'(busy),       16'h1);
    check("op1_exec_rdy",   16'(req0_ready), 16'h0);
    check("op1_exec_rspv",  16'(rsp0_valid), 16'h0);
    check("op1_alu_ain",    alu_ain,         16'h7FFF);
    check("op1_alu_bin",    alu_bin,         16'h0001);
    check("op1_alu_op",     16'(alu_op),     16'h0);
    tick();
    check("op1_rsp0_valid", 16'(rsp0_valid), 16'h1);
    check("op1_rsp1_valid", 16'(rsp1_valid), 16'h0);
    check("op1_rsp_data",   rsp_data,        16'h8000);
    check("op1_rsp_flags",  16'(rsp_flags),  16'h6);
    check("op1_status",     16'(status_nvz), 16'h6);
    rsp0_ready = 1'b1;
    tick();
    check("op1_done_busy",  16'(busy),       16'h0);
    check("op1_done_rspv",  16'(rsp0_valid), 16'h0);
    rsp0_ready = 1'b0;

    // ---- Back-pressure on requester 1: 0x0003 - 0x0001 ----
    req1_valid = 1'b1; req1_a = 16'h0003; req1_b = 16'h0001; req1_op = 2'b01;
    #1;
    check("bp_req1_ready",  16'(req1_ready), 16'h1);
    check("bp_req0_ready",  16'(req0_ready), 16'h0);
    tick();  // accept
    req1_valid = 1'b0;
    req0_valid = 1'b1;  // pending request must not be granted while busy
    tick();
    check("bp_rsp1_valid",  16'(rsp1_valid), 16'h1);
    check("bp_rsp_data",    rsp_data,        16'h0002);
    check("bp_rsp_flags",   16'(rsp_flags),  16'h0);
    for (int i = 0; i < 10; i++) begin
      rsp0_ready = (i % 2 == 0);
      tick();
      check("bp_hold_rsp1v", 16'(rsp1_valid), 16'h1);
      check("bp_hold_rsp0v", 16'(rsp0_valid), 16'h0);
      check("bp_hold_data",  rsp_data,        16'h0002);
      check("bp_hold_busy",  16'(busy),       16'h1);
      check("bp_hold_rdy0",  16'(req0_ready), 16'h0);
      check("bp_hold_rdy1",  16'(req1_ready), 16'h0);
    end
    rsp0_ready = 1'b0;
    req0_valid = 1'b0;
    rsp1_ready = 1'b1;
    tick();
    check("bp_done_busy",   16'(busy),       16'h0);
    check("bp_done_rsp1v",  16'(rsp1_valid), 16'h0);

    // ---- Tie and rotation: grants 0,1,0,1 (requester 1 served last) ----
    req0_a = 16'h1234; req0_b = 16'h0001; req0_op = 2'b00;  // -> 0x1235, 000
    req1_a = 16'h0005; req1_b = 16'h0005; req1_op = 2'b01;  // -> 0x0000, 001
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      logic exp_g;
      exp_g = (g % 2 == 1);
      check("tie_req0_ready", 16'(req0_ready), 16'(!exp_g));
      check("tie_req1_ready", 16'(req1_ready), 16'(exp_g));
      tick();  // accept
      tick();  // EXEC -> RESP
      check("tie_rsp0_valid", 16'(rsp0_valid), 16'(!exp_g));
      check("tie_rsp1_valid", 16'(rsp1_valid), 16'(exp_g));
      check("tie_rsp_data",   rsp_data,        exp_g ? 16'h0000 : 16'h1235);
      check("tie_rsp_flags",  16'(rsp_flags),  exp_g ? 16'h1 : 16'h0);
      tick();  // RESP -> IDLE
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("tie_status",     16'(status_nvz), 16'h1);

    // ---- Reset during EXEC ----
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; req0_op = 2'b00;
    #1;
    check("mid_req0_ready", 16'(req0_ready), 16'h1);
    tick();  // accept
    req0_valid = 1'b0;
    check("mid_exec_busy",  16'(busy),       16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   16'(busy),       16'h0);
    check("mid_rst_ain",    alu_ain,         16'h0000);
    check("mid_rst_bin",    alu_bin,         16'h0000);
    check("mid_rst_status", 16'(status_nvz), 16'h0);
    check("mid_rst_data",   rsp_data,        16'h0000);
    check("mid_rst_rsp0v",  16'(rsp0_valid), 16'h0);
    tick();
    rst_n = 1'b1;
    req1_valid = 1'b1; req1_a = 16'hF0F0; req1_b = 16'h0FF0; req1_op = 2'b10;
    #1;
    check("mid_rel_rdy1",   16'(req1_ready), 16'h0);
    tick();  // arming edge
    check("mid_post_rsp0v", 16'(rsp0_valid), 16'h0);
    check("mid_post_busy",  16'(busy),       16'h0);
    check("mid_post_rdy1",  16'(req1_ready), 16'h1);

    // ---- AND on requester 1 after reset ----
    tick();  // accept
    req1_valid = 1'b0;
    tick();
    check("and_rsp0_valid", 16'(rsp0_valid), 16'h0);
    check("and_rsp1_valid", 16'(rsp1_valid), 16'h1);
    check("and_rsp_data",   rsp_data,        16'h00F0);
    check("and_rsp_flags",  16'(rsp_flags),  16'h0);
    tick();

    // ---- NOT-B on requester 0 ----
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0000; req0_op = 2'b11;
    #1;
    check("not_req0_ready", 16'(req0_ready), 16'h1);
    tick();
    req0_valid = 1'b0;
    tick();
    check("not_rsp0_valid", 16'(rsp0_valid), 16'h1);
    check("not_rsp_data",   rsp_data,        16'hFFFF);
    check("not_rsp_flags",  16'(rsp_flags),  16'h4);
    check("not_status",     16'(status_nvz), 16'h4);
    tick();
    check("not_done_busy",  16'(busy),       16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
